// File: rtl/boid_cycle_timer.sv
// Cycle-accurate stopwatch for the boid update pass. Holds the last completed
// measurement on count_out so software never reads a half-counted value.
module boid_cycle_timer #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] live_count,
  output logic             running,
  output logic             overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [PW-1:0]     presc_r;
  logic [PW-1:0]     presc_nxt_s;
  logic [WIDTH-1:0]  live_nxt_s;
  logic [WIDTH-1:0]  count_nxt_s;
  logic              ovf_nxt_s;
  logic              tick_s;
  logic              sat_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear beats stop beats start
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) state_nxt_s = RUN;
          else       state_nxt_s = state_r;
        end
        RUN: begin
          if (stop) state_nxt_s = DONE;
          else      state_nxt_s = RUN;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  assign tick_s = (presc_r == PRESC_LAST);
  assign sat_s  = (live_count == ALL_ONES);

  // Datapath next values: prescaler, live counter, capture, sticky overflow
  always_comb begin
    presc_nxt_s = presc_r;
    live_nxt_s  = live_count;
    count_nxt_s = count_out;
    ovf_nxt_s   = overflow;
    if (clear) begin
      presc_nxt_s = '0;
      live_nxt_s  = '0;
      count_nxt_s = '0;
      ovf_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            presc_nxt_s = '0;
            live_nxt_s  = '0;
            ovf_nxt_s   = 1'b0;
          end else begin
            presc_nxt_s = presc_r;
          end
        end
        RUN: begin
          if (stop) begin
            // Capture includes a tick landing on the stop edge; live_count holds
            if (tick_s && !sat_s) begin
              count_nxt_s = live_count + WIDTH'(1'b1);
            end else begin
              count_nxt_s = live_count;
            end
            if (tick_s && sat_s) ovf_nxt_s = 1'b1;
            else                 ovf_nxt_s = overflow;
          end else if (start) begin
            presc_nxt_s = '0;
            live_nxt_s  = '0;
            ovf_nxt_s   = 1'b0;
          end else begin
            presc_nxt_s = tick_s ? '0 : presc_r + PW'(1'b1);
            if (tick_s && sat_s) begin
              ovf_nxt_s = 1'b1;
            end else if (tick_s) begin
              live_nxt_s = live_count + WIDTH'(1'b1);
            end else begin
              live_nxt_s = live_count;
            end
          end
        end
        default: begin
          presc_nxt_s = '0;
          live_nxt_s  = '0;
          count_nxt_s = '0;
          ovf_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs and prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r    <= '0;
      live_count <= '0;
      count_out  <= '0;
      overflow   <= 1'b0;
      running    <= 1'b0;
    end else begin
      presc_r    <= presc_nxt_s;
      live_count <= live_nxt_s;
      count_out  <= count_nxt_s;
      overflow   <= ovf_nxt_s;
      running    <= (state_nxt_s == RUN);
    end
  end

endmodule

// File: tb/tb_boid_cycle_timer.sv
// Directed bench for boid_cycle_timer: three instances cover raw counting,
// PRESCALE=4 and WIDTH=4 saturation.
module tb_boid_cycle_timer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] st = 3'b000;
  logic [2:0] sp = 3'b000;
  logic [2:0] cl = 3'b000;

  logic [31:0] cnt0, live0;
  logic [31:0] cnt1, live1;
  logic [3:0]  cnt2, live2;
  logic [2:0]  run, ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boid_cycle_timer #(.WIDTH(32), .PRESCALE(1)) u0 (
    .clk(clk), .reset_n(reset_n), .start(st[0]), .stop(sp[0]), .clear(cl[0]),
    .count_out(cnt0), .live_count(live0), .running(run[0]), .overflow(ovf[0]));
  boid_cycle_timer #(.WIDTH(32), .PRESCALE(4)) u1 (
    .clk(clk), .reset_n(reset_n), .start(st[1]), .stop(sp[1]), .clear(cl[1]),
    .count_out(cnt1), .live_count(live1), .running(run[1]), .overflow(ovf[1]));
  boid_cycle_timer #(.WIDTH(4), .PRESCALE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .start(st[2]), .stop(sp[2]), .clear(cl[2]),
    .count_out(cnt2), .live_count(live2), .running(run[2]), .overflow(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one-cycle control pulses to instance idx, sampled on the next edge
  task automatic pulse(input int idx, input bit s, input bit p, input bit c);
    st[idx] = s; sp[idx] = p; cl[idx] = c;
    step(1);
    st[idx] = 1'b0; sp[idx] = 1'b0; cl[idx] = 1'b0;
  endtask

  initial begin
    #12 reset_n = 1'b1;
    step(1);
    chk("reset_cnt0", cnt0, 0);
    chk("reset_live0", live0, 0);
    chk("reset_run0", {31'd0, run[0]}, 0);
    chk("reset_ovf0", {31'd0, ovf[0]}, 0);

    // Basic: stop 100 edges after start
    pulse(0, 1'b1, 1'b0, 1'b0);
    chk("start_run", {31'd0, run[0]}, 1);
    chk("start_live", live0, 0);
    step(1);
    chk("live_k1", live0, 1);
    step(98);
    chk("live_k99", live0, 99);
    pulse(0, 1'b0, 1'b1, 1'b0);
    chk("basic_cnt", cnt0, 100);
    chk("basic_run", {31'd0, run[0]}, 0);
    chk("basic_ovf", {31'd0, ovf[0]}, 0);
    step(50);
    chk("basic_hold_cnt", cnt0, 100);
    chk("basic_hold_live", live0, 99);
    pulse(0, 1'b0, 1'b1, 1'b0);
    chk("done_stop_ignored", cnt0, 100);

    // start+stop together in RUN: stop wins
    pulse(0, 1'b1, 1'b0, 1'b0);
    step(4);
    pulse(0, 1'b1, 1'b1, 1'b0);
    chk("prio_cnt", cnt0, 5);
    chk("prio_run", {31'd0, run[0]}, 0);

    // Restart mid-RUN
    pulse(0, 1'b1, 1'b0, 1'b0);
    step(29);
    pulse(0, 1'b1, 1'b0, 1'b0);
    chk("restart_live", live0, 0);
    chk("restart_cnt_kept", cnt0, 5);
    chk("restart_run", {31'd0, run[0]}, 1);
    step(19);
    pulse(0, 1'b0, 1'b1, 1'b0);
    chk("restart_cnt", cnt0, 20);

    // Clear beats stop
    pulse(0, 1'b1, 1'b0, 1'b0);
    step(10);
    pulse(0, 1'b0, 1'b1, 1'b1);
    chk("clear_cnt", cnt0, 0);
    chk("clear_live", live0, 0);
    chk("clear_run", {31'd0, run[0]}, 0);
    chk("clear_ovf", {31'd0, ovf[0]}, 0);
    pulse(0, 1'b0, 1'b1, 1'b0);
    chk("idle_stop_cnt", cnt0, 0);
    chk("idle_stop_run", {31'd0, run[0]}, 0);

    // Prescaled: live_count steps every 4th edge, result floor(103/4)
    pulse(1, 1'b1, 1'b0, 1'b0);
    chk("p4_live0", live1, 0);
    step(3);
    chk("p4_live_e3", live1, 0);
    step(1);
    chk("p4_live_e4", live1, 1);
    step(98);
    chk("p4_live_e102", live1, 25);
    pulse(1, 1'b0, 1'b1, 1'b0);
    chk("p4_cnt", cnt1, 25);
    chk("p4_run", {31'd0, run[1]}, 0);

    // Saturation at WIDTH=4
    pulse(2, 1'b1, 1'b0, 1'b0);
    step(14);
    chk("sat_live14", {28'd0, live2}, 14);
    step(1);
    chk("sat_live15", {28'd0, live2}, 15);
    chk("sat_ovf_not_yet", {31'd0, ovf[2]}, 0);
    step(1);
    chk("sat_live_hold", {28'd0, live2}, 15);
    chk("sat_ovf_set", {31'd0, ovf[2]}, 1);
    step(23);
    pulse(2, 1'b0, 1'b1, 1'b0);
    chk("sat_cnt", {28'd0, cnt2}, 15);
    chk("sat_ovf_sticky", {31'd0, ovf[2]}, 1);
    pulse(2, 1'b1, 1'b0, 1'b0);
    chk("sat_ovf_cleared", {31'd0, ovf[2]}, 0);
    chk("sat_live_cleared", {28'd0, live2}, 0);
    chk("sat_cnt_kept", {28'd0, cnt2}, 15);

    // Asynchronous reset between edges mid-RUN
    pulse(0, 1'b1, 1'b0, 1'b0);
    step(20);
    #3 reset_n = 1'b0;
    #1;
    chk("areset_live", live0, 0);
    chk("areset_run", {31'd0, run[0]}, 0);
    chk("areset_cnt1", cnt1, 0);
    chk("areset_cnt2", {28'd0, cnt2}, 0);
    #2 reset_n = 1'b1;
    step(1);
    pulse(0, 1'b1, 1'b0, 1'b0);
    step(6);
    pulse(0, 1'b0, 1'b1, 1'b0);
    chk("post_reset_cnt", cnt0, 7);
    chk("post_reset_run", {31'd0, run[0]}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boid_cycle_timer.md
# boid_cycle_timer

Cycle-accurate stopwatch that measures how long the boid update pass takes and presents the result as a stable 32-bit word to the `counter` PIO input port. The HPS reads that port over the lightweight bridge. Control pulses come from the boid engine or from a control PIO: `start` at frame begin, `stop` at frame end. Between measurements the block holds the last completed measurement, so software never reads a half-counted value.

## Interface
- `WIDTH`, default 32: width of the live counter and of the captured result (2–32).
- `PRESCALE`, default 1: clock cycles per count increment (≥1). A value of 1 counts raw cycles.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset; deassertion is synchronous to `clk` upstream.
- `start` input 1: single-cycle pulse; begins or restarts a measurement.
- `stop` input 1: single-cycle pulse; ends the measurement and captures the result.
- `clear` input 1: synchronous clear of all state back to IDLE.
- `count_out` output WIDTH: last captured measurement; drives the PIO `in_port`, zero-extended to 32 bits.
- `live_count` output WIDTH: running counter, for debug and SignalTap.
- `running` output 1: high while in RUN.
- `overflow` output 1: sticky; set when the counter saturates during a measurement.

## Operation
- There are three states: IDLE, RUN and DONE. Reset and `clear` go to IDLE.
- Input priority on any edge is `clear` > `stop` > `start`.
- IDLE:
  - `start` clears `live_count`, the prescaler and `overflow`, then moves to RUN.
  - `stop` is ignored.
- RUN:
  - The prescaler counts 0..PRESCALE-1. A tick occurs on the edge where it wraps to 0, and each tick increments `live_count`.
  - `stop` loads `count_out` with `live_count + tick` (saturating) and moves to DONE. `live_count` holds its value.
  - `start` without `stop` restarts the measurement: it clears `live_count`, the prescaler and `overflow`, and stays in RUN. `count_out` is unchanged.
- DONE:
  - `live_count` and `count_out` hold.
  - `start` behaves as it does in IDLE and moves to RUN.
  - `stop` is ignored.
- Saturation:
  - When `live_count` equals 2^WIDTH-1 and a tick occurs, it holds at all-ones and `overflow` is set.
  - `overflow` stays set until the next `start`, `clear` or reset.
  - A captured value from a saturated run is all-ones.
- `clear`, in any state:
  - Zeroes `live_count`, `count_out`, the prescaler and `overflow`.
  - Goes to IDLE and lowers `running`.
- All arithmetic is unsigned, WIDTH bits. Increments never wrap.

## Timing
- Reset values:
  - `count_out` = 0
  - `live_count` = 0
  - `running` = 0
  - `overflow` = 0
  - state = IDLE
  - prescaler = 0
- `start` sampled at edge E:
  - After E: `running` = 1 and `live_count` = 0.
  - With PRESCALE=1, `live_count` = k after edge E+k.
- `stop` sampled at edge E+N, with PRESCALE=1:
  - `count_out` = N after edge E+N.
  - `running` = 0 after the same edge.
- With general PRESCALE, `count_out` = floor(N / PRESCALE).
- Latency is one cycle from any control pulse to every output. All outputs are registered, and there is no combinational path from inputs to outputs.
- A `start` and `stop` held for several cycles act on every edge. Upstream must drive single-cycle pulses.
- Reset asserted mid-RUN forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- Basic, PRESCALE=1: reset, `start` at edge 10, `stop` at edge 110 → `count_out` = 100, `running` = 0, `overflow` = 0. `count_out` holds at 100 for a further 50 cycles.
- Prescaled, PRESCALE=4: `start`, then `stop` 103 cycles later → `count_out` = 25. `live_count` changes only every 4th cycle.
- Restart and priority:
  - `start`, then a second `start` 30 cycles later, then `stop` 20 cycles after that → `count_out` = 20.
  - `start` and `stop` together in RUN → `stop` wins and the state goes to DONE.
- Saturation, WIDTH=4: `start`, then `stop` 40 cycles later → `live_count` holds at 15 from cycle 15, `overflow` = 1, `count_out` = 15. The next `start` clears `overflow`.
- Clear: mid-RUN `clear` together with `stop` → all outputs are 0 and the state is IDLE. A `stop` in IDLE has no effect.
- Asynchronous reset: pull `reset_n` low mid-RUN, between edges → all outputs are 0 before the next rising edge. After release, `start`/`stop` measure normally.
